// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer geometry and Gray/binary conversion.
// Used by the write-side fill monitor, the write-pointer/full logic and
// the read-side empty logic.
package fifo_pkg;

    // Widest pointer the conversion helpers handle.
    localparam int unsigned GRAY_MAX_W = 32;

    // FIFO depth for a given address width.
    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // Pointer width: one extra wrap bit above the address.
    function automatic int unsigned ptr_width(input int unsigned aw);
        return aw + 32'd1;
    endfunction

    // Mask selecting the low w bits of a GRAY_MAX_W-bit word.
    function automatic logic [GRAY_MAX_W-1:0] width_mask(input int unsigned w);
        if (w >= GRAY_MAX_W)
            return '1;
        else
            return (GRAY_MAX_W'(1) << w) - GRAY_MAX_W'(1);
    endfunction

    // Gray to binary for a w-bit code: each binary bit is the XOR of all
    // Gray bits at or above it, i.e. the XOR of every right shift.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g,
                                                       input int unsigned            w);
        logic [GRAY_MAX_W-1:0] gm;
        logic [GRAY_MAX_W-1:0] b;
        gm = g & width_mask(w);
        b  = gm;
        for (int unsigned k = 1; k < GRAY_MAX_W; k++)
            b = b ^ (gm >> k);
        return b;
    endfunction

    // Binary to Gray for a w-bit value.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b,
                                                       input int unsigned            w);
        logic [GRAY_MAX_W-1:0] bm;
        bm = b & width_mask(w);
        return bm ^ (bm >> 1);
    endfunction

endpackage

// File: rtl/sync_bus_ff.sv
// Generic STAGES-deep, W-bit flop synchronizer with async active-low reset.
// Only valid for buses that change by at most one bit per source-clock
// cycle (Gray pointers). No logic between stages.
module sync_bus_ff #(
    parameter int unsigned W      = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sync_q [STAGES];
    logic [W-1:0] sync_d [STAGES];

    // Next-state of the chain: stage 0 takes the input, others shift.
    always_comb begin
        sync_d[0] = d;
        for (int unsigned i = 1; i < STAGES; i++)
            sync_d[i] = sync_q[i-1];
    end

    // Synchronizer flops, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++)
                sync_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < STAGES; i++)
                sync_q[i] <= sync_d[i];
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/wfill_monitor.sv
// Write-domain read-pointer receiver and fill-level tracker.
// Synchronizes the Gray read pointer into wclk, decodes both pointers and
// registers occupancy and almost-full. Defining WFILL_CHECK_EN adds a
// sticky flag for pointer pairs where the read side appears ahead.
module wfill_monitor
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 3,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned AFULL_THRESH = 6
) (
    input  logic                wclk,
    input  logic                rst_n,
    input  logic [ADDR_WIDTH:0] rptr,
    input  logic [ADDR_WIDTH:0] wptr,
    input  logic                err_clr,
    output logic [ADDR_WIDTH:0] rptr_sync,
    output logic [ADDR_WIDTH:0] wlevel,
    output logic                almost_full,
    output logic                wfill_err
);

    localparam int unsigned PTR_W = ptr_width(ADDR_WIDTH);
    localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] diff;

    logic [PTR_W-1:0] wlevel_d, wlevel_q;
    logic             afull_d,  afull_q;

    sync_bus_ff #(
        .W      (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk   (wclk),
        .rst_n (rst_n),
        .d     (rptr),
        .q     (rptr_sync)
    );

    // Decode both pointers and form the modulo occupancy.
    always_comb begin
        rbin = PTR_W'(gray2bin(GRAY_MAX_W'(rptr_sync), PTR_W));
        wbin = PTR_W'(gray2bin(GRAY_MAX_W'(wptr), PTR_W));
        diff = wbin - rbin;
    end

    // Next-state for the level and almost-full registers.
    always_comb begin
        wlevel_d = diff;
        afull_d  = (diff >= PTR_W'(AFULL_THRESH));
    end

    // Level and almost-full registers.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            wlevel_q <= '0;
            afull_q  <= 1'b0;
        end else begin
            wlevel_q <= wlevel_d;
            afull_q  <= afull_d;
        end
    end

    assign wlevel      = wlevel_q;
    assign almost_full = afull_q;

`ifdef WFILL_CHECK_EN
    logic err_set;
    logic err_d, err_q;

    // Sticky error: set beats clear, clear beats hold.
    always_comb begin
        err_set = (diff > PTR_W'(DEPTH));
        err_d   = err_q;
        if (err_set)
            err_d = 1'b1;
        else if (err_clr)
            err_d = 1'b0;
    end

    // Error register.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign wfill_err = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign wfill_err      = 1'b0;
`endif

endmodule

// File: tb/tb_wfill_monitor.sv
// Self-checking bench for wfill_monitor (ADDR_WIDTH=3, SYNC_STAGES=2,
// AFULL_THRESH=6). Works with and without WFILL_CHECK_EN.
module tb_wfill_monitor;

`ifdef WFILL_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic       wclk = 1'b0;
    logic       rst_n;
    logic [3:0] rptr, wptr;
    logic       err_clr;
    logic [3:0] rptr_sync, wlevel;
    logic       almost_full, wfill_err;

    int checks   = 0;
    int failures = 0;

    wfill_monitor #(
        .ADDR_WIDTH   (3),
        .SYNC_STAGES  (2),
        .AFULL_THRESH (6)
    ) dut (
        .wclk        (wclk),
        .rst_n       (rst_n),
        .rptr        (rptr),
        .wptr        (wptr),
        .err_clr     (err_clr),
        .rptr_sync   (rptr_sync),
        .wlevel      (wlevel),
        .almost_full (almost_full),
        .wfill_err   (wfill_err)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic [3:0]  rptr;
        logic [3:0]  wptr;
        logic        clr;
        int unsigned cyc;
        logic [3:0]  sync;
        logic [3:0]  lvl;
        logic        af;
        logic        err;   // expected only when the check is built in
    } vec_t;

    typedef struct {
        int         idx;
        logic [3:0] sync;
        logic [3:0] lvl;
        logic       af;
        logic       err;
    } exp_t;

    vec_t vt[10];
    exp_t sb[$];

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic [3:0] s, input logic [3:0] l,
                           input logic a, input logic e);
        chk({nm, "_sync"}, rptr_sync, s);
        chk({nm, "_lvl"}, wlevel, l);
        chk({nm, "_af"}, {3'b0, almost_full}, {3'b0, a});
        chk({nm, "_err"}, {3'b0, wfill_err}, {3'b0, e});
    endtask

    task automatic run_vec(input int i);
        exp_t e;
        rptr    = vt[i].rptr;
        wptr    = vt[i].wptr;
        err_clr = vt[i].clr;
        sb.push_back('{i, vt[i].sync, vt[i].lvl, vt[i].af, vt[i].err & CHK});
        repeat (vt[i].cyc) tick();
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty vec=%0d", i);
        end else begin
            e = sb.pop_front();
            chk_all($sformatf("v%0d", e.idx), e.sync, e.lvl, e.af, e.err);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        //          rptr     wptr     clr cyc sync     lvl  af    err
        vt[0] = '{4'b0000, 4'b0101, 1'b0, 3, 4'b0000, 4'd6, 1'b1, 1'b0};
        vt[1] = '{4'b0000, 4'b0111, 1'b0, 1, 4'b0000, 4'd5, 1'b0, 1'b0};
        vt[2] = '{4'b0000, 4'b0101, 1'b0, 1, 4'b0000, 4'd6, 1'b1, 1'b0};
        vt[3] = '{4'b1010, 4'b0110, 1'b0, 3, 4'b1010, 4'd8, 1'b1, 1'b0};
        vt[4] = '{4'b1010, 4'b0011, 1'b0, 1, 4'b1010, 4'd6, 1'b1, 1'b0};
        vt[5] = '{4'b0001, 4'b1111, 1'b0, 3, 4'b0001, 4'd9, 1'b1, 1'b1};
        vt[6] = '{4'b0001, 4'b1111, 1'b1, 1, 4'b0001, 4'd9, 1'b1, 1'b1};
        vt[7] = '{4'b0001, 4'b0001, 1'b0, 1, 4'b0001, 4'd0, 1'b0, 1'b1};
        vt[8] = '{4'b0001, 4'b0001, 1'b1, 1, 4'b0001, 4'd0, 1'b0, 1'b0};
        vt[9] = '{4'b0001, 4'b0100, 1'b0, 1, 4'b0001, 4'd6, 1'b1, 1'b0};

        // Reset with rptr=0101 (bin 6), wptr=0111 (bin 5)
        rst_n   = 1'b0;
        rptr    = 4'b0101;
        wptr    = 4'b0111;
        err_clr = 1'b0;
        #2;
        chk_all("rst0", 4'h0, 4'h0, 1'b0, 1'b0);
        tick();
        chk_all("rst1", 4'h0, 4'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_all("rel1", 4'b0000, 4'd5, 1'b0, 1'b0);
        tick();
        chk("rel2_sync", rptr_sync, 4'b0101);
        chk("rel2_lvl", wlevel, 4'd5);
        tick();
        // 5 - 6 wraps to 15: read side ahead
        chk_all("rel3", 4'b0101, 4'd15, 1'b1, CHK);

        wptr = 4'b0101;
        tick();
        chk_all("eq", 4'b0101, 4'd0, 1'b0, CHK);
        err_clr = 1'b1;
        tick();
        chk("eq_clr_err", {3'b0, wfill_err}, 4'h0);
        err_clr = 1'b0;

        // Threshold boundary
        for (int i = 0; i < 3; i++) run_vec(i);

        // Read-pointer latency with wptr=0101 held
        rptr = 4'b0010;
        tick();
        chk("lat1_sync", rptr_sync, 4'b0000);
        chk("lat1_lvl", wlevel, 4'd6);
        tick();
        chk("lat2_sync", rptr_sync, 4'b0010);
        chk("lat2_lvl", wlevel, 4'd6);
        tick();
        chk_all("lat3", 4'b0010, 4'd3, 1'b0, 1'b0);

        // Wrap, full, error set/clear priority
        for (int i = 3; i < 10; i++) run_vec(i);

        // Mid-operation reset between edges
        #3 rst_n = 1'b0;
        #1;
        chk_all("mrst", 4'h0, 4'h0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        tick();
        chk_all("mrel1", 4'b0000, 4'd7, 1'b1, 1'b0);
        tick();
        chk("mrel2_sync", rptr_sync, 4'b0001);
        tick();
        chk_all("mrel3", 4'b0001, 4'd6, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
